// File: rtl/msg_sequencer.sv
// rtl/msg_sequencer.sv - walks a 16-entry message ROM from start to end address, dwelling DWELL cycles per entry
module msg_sequencer #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] start_addr,
    input  logic [3:0] end_addr,
    input  logic       req,
    output logic [3:0] rom_addr,
    output logic       valid,
    output logic       busy,
    output logic       done
);

    typedef enum logic {IDLE, PLAY} state_t;

    localparam logic [7:0] LAST = 8'(DWELL - 1);

    state_t     state;
    logic [7:0] cnt;
    logic [3:0] end_q;
    logic       req_q;
    logic       start;

    assign start = req & ~req_q;
    assign busy  = valid;

    // A fresh rising edge of req always wins, even over the final dwell cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rom_addr <= 4'd0;
            valid    <= 1'b0;
            done     <= 1'b0;
            cnt      <= 8'd0;
            end_q    <= 4'd0;
            req_q    <= 1'b0;
        end else begin
            req_q <= req;
            done  <= 1'b0;
            if (start) begin
                state    <= PLAY;
                rom_addr <= start_addr;
                end_q    <= end_addr;
                cnt      <= 8'd0;
                valid    <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        valid <= 1'b0;
                    end
                    PLAY: begin
                        if (cnt == LAST) begin
                            cnt <= 8'd0;
                            if (rom_addr != end_q) begin
                                rom_addr <= rom_addr + 4'd1;
                            end else begin
                                state <= IDLE;
                                valid <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_msg_sequencer.sv
// tb/tb_msg_sequencer.sv - bench for msg_sequencer with DWELL=1,2,3 instances driven in parallel
module tb_msg_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] start_addr;
    logic [3:0] end_addr;
    logic       req;

    logic [3:0] ra [3];
    logic       va [3];
    logic       bu [3];
    logic       dn [3];

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    msg_sequencer #(.DWELL(1)) u_d1 (.clk(clk), .rst(rst), .start_addr(start_addr), .end_addr(end_addr),
        .req(req), .rom_addr(ra[0]), .valid(va[0]), .busy(bu[0]), .done(dn[0]));
    msg_sequencer #(.DWELL(2)) u_d2 (.clk(clk), .rst(rst), .start_addr(start_addr), .end_addr(end_addr),
        .req(req), .rom_addr(ra[1]), .valid(va[1]), .busy(bu[1]), .done(dn[1]));
    msg_sequencer #(.DWELL(3)) u_d3 (.clk(clk), .rst(rst), .start_addr(start_addr), .end_addr(end_addr),
        .req(req), .rom_addr(ra[2]), .valid(va[2]), .busy(bu[2]), .done(dn[2]));

    // Reference: elapsed cycles since start; address = start + elapsed/dwell, playing while elapsed < len*dwell.
    logic       m_req_q;
    int         m_t    [3];
    int         m_len  [3];
    logic [3:0] m_s    [3];
    logic       m_play [3];
    logic [3:0] m_addr [3];
    logic       m_v    [3];
    logic       m_d    [3];

    task automatic model_reset();
        m_req_q = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_t[i] = 0; m_len[i] = 0; m_s[i] = 4'd0; m_play[i] = 1'b0;
            m_addr[i] = 4'd0; m_v[i] = 1'b0; m_d[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        logic st;
        st = req & ~m_req_q;
        m_req_q = req;
        for (int i = 0; i < 3; i++) begin
            m_d[i] = 1'b0;
            if (st) begin
                m_s[i]    = start_addr;
                m_len[i]  = ((int'(end_addr) - int'(start_addr)) & 15) + 1;
                m_t[i]    = 0;
                m_play[i] = 1'b1;
                m_addr[i] = start_addr;
                m_v[i]    = 1'b1;
            end else if (m_play[i]) begin
                m_t[i]++;
                if (m_t[i] < m_len[i] * (i + 1)) begin
                    m_addr[i] = 4'((int'(m_s[i]) + m_t[i] / (i + 1)) & 15);
                    m_v[i]    = 1'b1;
                end else begin
                    m_play[i] = 1'b0;
                    m_v[i]    = 1'b0;
                    m_d[i]    = 1'b1;
                end
            end else begin
                m_v[i] = 1'b0;
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic check_model(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s d%0d rom_addr", tag, i + 1), int'(ra[i]), int'(m_addr[i]));
            check($sformatf("%s d%0d valid", tag, i + 1), int'(va[i]), int'(m_v[i]));
            check($sformatf("%s d%0d busy", tag, i + 1), int'(bu[i]), int'(m_v[i]));
            check($sformatf("%s d%0d done", tag, i + 1), int'(dn[i]), int'(m_d[i]));
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    typedef struct {
        logic       req;
        logic [3:0] s;
        logic [3:0] e;
        logic [3:0] exp_addr;
        logic       exp_valid;
        logic       exp_done;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int dcnt, vcnt;
        logic [3:0] wrap_exp [4];

        vecs[0] = '{1'b1, 4'd5, 4'd6, 4'd5, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 4'd5, 4'd6, 4'd5, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 4'd5, 4'd6, 4'd6, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 4'd5, 4'd6, 4'd6, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 4'd5, 4'd6, 4'd6, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 4'd5, 4'd6, 4'd6, 1'b0, 1'b0};

        rst = 1'b1; req = 1'b0; start_addr = 4'd0; end_addr = 4'd0;
        model_reset();
        #3;
        check_model("reset");
        @(posedge clk); #1; rst = 1'b0;
        for (int k = 0; k < 3; k++) tick("idle");

        // Basic DWELL=2 walk from a vector table
        for (int k = 0; k < 6; k++) begin
            req = vecs[k].req; start_addr = vecs[k].s; end_addr = vecs[k].e;
            tick("table");
            check($sformatf("vec%0d rom_addr", k), int'(ra[1]), int'(vecs[k].exp_addr));
            check($sformatf("vec%0d valid", k), int'(va[1]), int'(vecs[k].exp_valid));
            check($sformatf("vec%0d done", k), int'(dn[1]), int'(vecs[k].exp_done));
        end
        for (int k = 0; k < 8; k++) tick("drain");

        // Wrap 14 -> 1 on DWELL=1
        wrap_exp[0] = 4'd14; wrap_exp[1] = 4'd15; wrap_exp[2] = 4'd0; wrap_exp[3] = 4'd1;
        req = 1'b1; start_addr = 4'd14; end_addr = 4'd1;
        for (int k = 0; k < 4; k++) begin
            tick("wrap");
            req = 1'b0;
            check($sformatf("wrap addr%0d", k), int'(ra[0]), int'(wrap_exp[k]));
            check($sformatf("wrap valid%0d", k), int'(va[0]), 1);
        end
        tick("wrap");
        check("wrap done", int'(dn[0]), 1);
        check("wrap end valid", int'(va[0]), 0);
        for (int k = 0; k < 12; k++) tick("drain");

        // Single address on DWELL=3
        req = 1'b1; start_addr = 4'd0; end_addr = 4'd0;
        for (int k = 0; k < 3; k++) begin
            tick("single");
            req = 1'b0;
            check($sformatf("single valid%0d", k), int'(va[2]), 1);
            check($sformatf("single done%0d", k), int'(dn[2]), 0);
        end
        tick("single");
        check("single done", int'(dn[2]), 1);
        for (int k = 0; k < 4; k++) tick("drain");

        // Level hold: one playback only
        req = 1'b1; start_addr = 4'd3; end_addr = 4'd4;
        dcnt = 0; vcnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick("hold");
            dcnt += int'(dn[1]);
            vcnt += int'(va[1]);
        end
        check("hold done count", dcnt, 1);
        check("hold valid cycles", vcnt, 4);
        req = 1'b0;
        tick("hold");

        // Restart mid-sequence: no done for the aborted range, then 8..12
        req = 1'b1; start_addr = 4'd0; end_addr = 4'd7;
        tick("restart");
        req = 1'b0;
        for (int k = 0; k < 3; k++) tick("restart");
        req = 1'b1; start_addr = 4'd8; end_addr = 4'd12;
        tick("restart");
        check("restart jump", int'(ra[1]), 8);
        req = 1'b0; start_addr = 4'd1; end_addr = 4'd2;
        dcnt = 0;
        for (int k = 1; k <= 10; k++) begin
            tick("restart");
            if (k < 10) dcnt += int'(dn[1]);
        end
        check("restart no early done", dcnt, 0);
        check("restart done", int'(dn[1]), 1);
        check("restart end addr", int'(ra[1]), 12);
        for (int k = 0; k < 20; k++) tick("drain");

        // Asynchronous reset mid-play
        req = 1'b1; start_addr = 4'd9; end_addr = 4'd13;
        tick("prerst");
        req = 1'b0;
        for (int k = 0; k < 2; k++) tick("prerst");
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_model("async_rst");
        @(posedge clk); #1; rst = 1'b0;
        for (int k = 0; k < 4; k++) tick("post_rst");

        // Randomized stimulus with input churn during playback
        for (int k = 0; k < 600; k++) begin
            req = ($urandom_range(0, 9) < 2);
            start_addr = 4'($urandom);
            end_addr = 4'($urandom);
            tick("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
